// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Sync byte plus the two word-count bytes.
    localparam int HDR_LEN = 3;

endpackage

// File: rtl/imem_word_asm.sv
// Little-endian word assembler: collects four stream bytes into one 32-bit word.
// Part of imem_loader; IMEM_LOADER_CHECKSUM_EN does not affect this block.
module imem_word_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  byte_idx;
    logic [23:0] shift_reg;

    // Bytes enter at the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx  <= 2'd0;
            shift_reg <= 24'd0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            shift_reg <= 24'd0;
        end else if (accept) begin
            byte_idx  <= byte_idx + 2'd1;
            shift_reg <= {byte_in, shift_reg[23:8]};
        end
    end

    assign word      = {byte_in, shift_reg};
    assign word_done = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a sync/count/data byte frame and writes instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ROM_SIZE  = 32,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic                        rx_ready,
    input  logic                        reload,
    output logic                        imem_we,
    output logic [$clog2(ROM_SIZE)-1:0] imem_addr,
    output logic [31:0]                 imem_wdata,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        error
);

    localparam int ADDR_W = $clog2(ROM_SIZE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = ST_CSUM;
`else
    localparam loader_state_t END_STATE = ST_DONE;
`endif

    loader_state_t state, next_state;
    logic [15:0]   count;
    logic [15:0]   word_cnt;
    logic [15:0]   count_full;
    logic          accept;
    logic          last_word;
    logic [31:0]   asm_word;
    logic          word_done;
    logic          stay_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign rx_ready   = (state != ST_DONE) && (state != ST_ERR);
    assign accept     = rx_valid && rx_ready;
    assign count_full = {rx_data, count[7:0]};
    assign last_word  = (word_cnt + 16'd1) == count;
    assign error      = (state == ST_ERR);
    assign stay_done  = (state == ST_DONE) && (next_state == ST_DONE);

    imem_word_asm u_word_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state != ST_DATA),
        .accept    (accept && (state == ST_DATA)),
        .byte_in   (rx_data),
        .word      (asm_word),
        .word_done (word_done)
    );

    // Frame parser next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept && rx_data == SYNC_BYTE) next_state = ST_CNT_LO;
            ST_CNT_LO: if (accept) next_state = ST_CNT_HI;
            ST_CNT_HI: begin
                if (accept) begin
                    if (count_full > 16'(ROM_SIZE))
                        next_state = ST_ERR;
                    else if (count_full == 16'd0)
                        next_state = END_STATE;
                    else
                        next_state = ST_DATA;
                end
            end
            ST_DATA:   if (word_done && last_word) next_state = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM:   if (accept) next_state = (rx_data == csum) ? ST_DONE : ST_ERR;
`endif
            ST_DONE,
            ST_ERR:    if (reload) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // done/cpu_hold lag DONE entry by a cycle so release follows the last write pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= 16'd0;
            word_cnt   <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state    <= next_state;
            imem_we  <= 1'b0;
            done     <= stay_done;
            cpu_hold <= !stay_done;
            if (state == ST_IDLE)
                word_cnt <= 16'd0;
            if (state == ST_CNT_LO && accept)
                count[7:0] <= rx_data;
            if (state == ST_CNT_HI && accept)
                count[15:8] <= rx_data;
            if (word_done) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= asm_word;
                word_cnt   <= word_cnt + 16'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every byte after sync, checked against the trailing byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (state == ST_IDLE) begin
            csum <= 8'd0;
        end else if (accept && (state == ST_CNT_LO || state == ST_CNT_HI || state == ST_DATA)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader using a write scoreboard.
// Checksum scenarios run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ROM_SIZE = 32;
    localparam int AW       = $clog2(ROM_SIZE);

    logic          clk;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [31:0]   frame_words[$];

    imem_loader #(.ROM_SIZE(ROM_SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every write pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            vectors++;
            if (exp_addr.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                logic [AW-1:0] ea;
                logic [31:0]   ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (imem_addr !== ea || imem_wdata !== ed) begin
                    miscompares++;
                    $display("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", imem_addr, imem_wdata, ea, ed);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: rx_ready=%b, required 1", rx_ready);
        end else begin
            @(posedge clk); #1;
        end
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // csum_mode: 0 = no checksum byte, 1 = correct, 2 = corrupted (ignored when disabled).
    task automatic send_frame(input logic [15:0] count, input int gap, input int csum_mode);
        logic [7:0]  bq[$];
        logic [7:0]  csum;
        logic [31:0] w;
        csum = count[7:0] ^ count[15:8];
        bq.push_back(8'hA5);
        bq.push_back(count[7:0]);
        bq.push_back(count[15:8]);
        for (int i = 0; i < frame_words.size(); i++) begin
            w = frame_words[i];
            exp_addr.push_back(AW'(i));
            exp_data.push_back(w);
            for (int k = 0; k < 4; k++) begin
                bq.push_back(w[8*k +: 8]);
                csum = csum ^ w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (csum_mode != 0)
            bq.push_back(csum ^ ((csum_mode == 2) ? 8'h03 : 8'h00));
`else
        if (csum_mode == 2)
            $display("[TB] checksum disabled, corrupted checksum not sent (csum=%h)", csum);
`endif
        for (int i = 0; i < bq.size(); i++)
            send_byte(bq[i], (i == bq.size() - 1) ? 0 : gap);
        rx_valid = 1'b0;
        frame_words.delete();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (rx_ready !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %b, required 1", rx_ready); end
        vectors++; if (cpu_hold !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_cpu_hold: got %b, required 1", cpu_hold); end
        vectors++; if (imem_we !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_we: got %b, required 0", imem_we); end
        vectors++; if (imem_addr !== '0)    begin miscompares++; $display("[TB] FAIL reset_addr: got %0d, required 0", imem_addr); end
        vectors++; if (imem_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h, required 0", imem_wdata); end
        vectors++; if (done !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
        vectors++; if (error !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_error: got %b, required 0", error); end
        reset = 1'b0;
    endtask

    task automatic test_two_words(input int gap, input string tag);
        frame_words.push_back(32'h12345678);
        frame_words.push_back(32'hDEADBEEF);
        send_frame(16'd2, gap, 1);
        vectors++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_early_done: got done=%b hold=%b, required done=0 hold=1", tag, done, cpu_hold); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_done: got done=%b hold=%b, required done=1 hold=0", tag, done, cpu_hold); end
        vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_ready_in_done: got %b, required 0", tag, rx_ready); end
        vectors++; if (exp_addr.size() != 0) begin miscompares++; $display("[TB] FAIL %s_writes_missing: got %0d pending, required 0", tag, exp_addr.size()); end
        pulse_reload();
        vectors++; if (done !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_reload: got done=%b hold=%b ready=%b, required 0 1 1", tag, done, cpu_hold, rx_ready); end
    endtask

    task automatic test_junk();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        frame_words.push_back(32'hCAFEF00D);
        send_frame(16'd1, 0, 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL junk_done: got done=%b error=%b, required 1 0", done, error); end
        vectors++; if (exp_addr.size() != 0) begin miscompares++; $display("[TB] FAIL junk_writes_missing: got %0d pending, required 0", exp_addr.size()); end
        pulse_reload();
    endtask

    task automatic test_zero_count();
        send_frame(16'd0, 0, 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done: got done=%b hold=%b, required 1 0", done, cpu_hold); end
        pulse_reload();
    endtask

    task automatic test_oversize();
        send_frame(16'h0021, 0, 0);
        vectors++; if (error !== 1'b1 || rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL oversize_err: got error=%b ready=%b, required 1 0", error, rx_ready); end
        vectors++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL oversize_hold: got hold=%b done=%b, required 1 0", cpu_hold, done); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (error !== 1'b1) begin miscompares++; $display("[TB] FAIL oversize_sticky: got %b, required 1", error); end
        pulse_reload();
        vectors++; if (error !== 1'b0 || rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL oversize_reload: got error=%b ready=%b, required 0 1", error, rx_ready); end
    endtask

    task automatic test_max_count();
        for (int i = 0; i < ROM_SIZE; i++)
            frame_words.push_back($urandom);
        send_frame(16'(ROM_SIZE), 0, 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL max_done: got done=%b error=%b, required 1 0", done, error); end
        vectors++; if (exp_addr.size() != 0) begin miscompares++; $display("[TB] FAIL max_writes_missing: got %0d pending, required 0", exp_addr.size()); end
        pulse_reload();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (rx_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ctrl: got ready=%b hold=%b done=%b error=%b, required 1 1 0 0", rx_ready, cpu_hold, done, error); end
        vectors++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL midreset_port: got we=%b addr=%0d data=%h, required 0 0 0", imem_we, imem_addr, imem_wdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        frame_words.push_back(32'hA1B2C3D4);
        send_frame(16'd1, 0, 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_done: got %b, required 1", done); end
        vectors++; if (exp_addr.size() != 0) begin miscompares++; $display("[TB] FAIL midreset_writes_missing: got %0d pending, required 0", exp_addr.size()); end
        pulse_reload();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        frame_words.push_back(32'h04030201);
        send_frame(16'd1, 0, 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL csum_good: got done=%b error=%b, required 1 0", done, error); end
        pulse_reload();
        frame_words.push_back(32'h04030201);
        send_frame(16'd1, 0, 2);
        vectors++; if (error !== 1'b1 || cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL csum_bad: got error=%b hold=%b, required 1 1", error, cpu_hold); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL csum_bad_hold: got done=%b hold=%b, required 0 1", done, cpu_hold); end
        vectors++; if (exp_addr.size() != 0) begin miscompares++; $display("[TB] FAIL csum_writes_missing: got %0d pending, required 0", exp_addr.size()); end
        pulse_reload();
    endtask
`endif

    initial begin
        test_reset();
        test_two_words(0, "stream");
        test_junk();
        test_zero_count();
        test_oversize();
        test_max_count();
        test_reset_mid_frame();
        test_two_words(1, "throttled");
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (exp_addr.size() != 0) begin miscompares++; $display("[TB] FAIL final_pending: got %0d, required 0", exp_addr.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one write per word to the instruction-memory write port. It holds the core stalled via `cpu_hold` until a complete, well-formed image has been written. It sits between the UART receiver and the instruction memory.

## Interface
- `ROM_SIZE`, 32, instruction-memory depth in 32-bit words; the maximum accepted word count.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader can accept a byte; a byte is accepted on a rising edge with `rx_valid && rx_ready`.
- `reload`  in  1  single-cycle request to start a new load from DONE or ERR.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  $clog2(ROM_SIZE)  word address.
- `imem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  drives the fetch stage's PC/IF-ID stall and keeps the core in reset.
- `done`  out  1  image loaded; core released.
- `error`  out  1  malformed frame.

## Operation
- Frame format: `SYNC_BYTE`, count_lo, count_hi (16-bit word count N), then 4·N data bytes, each word little-endian (first byte goes to bits 7:0).
- States:
  - IDLE: wait for sync. Non-sync bytes are accepted and discarded. Sync goes to CNT_LO.
  - CNT_LO: capture the low count byte, then go to CNT_HI.
  - CNT_HI: capture the high byte. If N > ROM_SIZE, go to ERR. If N == 0, go to DONE (CSUM when the checksum feature is enabled). Otherwise go to DATA.
  - DATA: a byte index counts 0..3. Acceptance of byte 3 loads `imem_wdata` and `imem_addr` = word index and pulses `imem_we`. After word N−1, go to DONE (CSUM when the checksum feature is enabled).
  - DONE: `done`=1, `cpu_hold`=0. `reload` goes to IDLE.
  - ERR: `error`=1, `cpu_hold`=1. `reload` goes to IDLE.
- `rx_ready` = 1 in IDLE, CNT_LO, CNT_HI, DATA and CSUM; 0 in DONE and ERR. It is decoded from state.
- `reload` is ignored outside DONE and ERR.
- Word address starts at 0 and increments by 1 per word. It never wraps, because N ≤ ROM_SIZE is checked before DATA.
- Memory already written is not cleared on error or reload.

## Timing
- Reset values:
  - state IDLE, so `rx_ready`=1.
  - `cpu_hold`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `done`=0, `error`=0.
  - byte and word counters 0.
- `imem_we` rises in the cycle after the edge that accepts byte 3 of a word and stays high for exactly one cycle. `imem_addr` and `imem_wdata` are stable during that cycle.
- Back-to-back bytes are accepted every cycle. A write cycle never stalls acceptance of the next word's first byte.
- `done` and the deassertion of `cpu_hold` occur in the cycle after the last write pulse, or after CSUM acceptance when the checksum feature is enabled.
- `reload` in DONE: `cpu_hold`=1 and `done`=0 on the next edge.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. A partial word is discarded.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A CSUM state follows the last data byte; N==0 also goes through CSUM.
  - The expected value is the XOR of every byte after sync (count bytes plus data bytes).
  - Match goes to DONE; mismatch goes to ERR.
  - Words are still written before the check, but `cpu_hold` stays 1 on mismatch.
- Undefined: no CSUM state; the frame ends after the last data byte.

## Structure
- Package `imem_loader_pkg` holds:
  - the state encoding (IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR);
  - the default `SYNC_BYTE`;
  - the frame header length constant.
- One sub-module, `imem_word_asm`, contains the byte-index counter and the little-endian shift register. It outputs the assembled word and a word-complete pulse.

## Test plan
- Stream A5 02 00 78 56 34 12 EF BE AD DE:
  - two writes: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF, each a one-cycle `imem_we`;
  - then `done`=1 and `cpu_hold`=0.
- Junk bytes 00 FF before A5 01 00 + 4 bytes: junk is discarded, one write to addr 0, `done`=1.
- Count 0x0021 with ROM_SIZE=32: ERR, `error`=1, `rx_ready`=0, no `imem_we`. A `reload` pulse returns to IDLE.
- Reset asserted after 2 data bytes, then a full 1-word frame: no write from the partial word, and the new word is written to addr 0.
- Checksum feature enabled, frame A5 01 00 01 02 03 04 + CSUM:
  - CSUM 0x05 gives `done`=1;
  - CSUM 0x06 gives `error`=1 and `cpu_hold`=1.
- `rx_valid` toggled every other cycle: the written words are identical to the continuous-stream case.
